// File: rtl/bram_burst_reader_if.sv
// ---------------------------------------------------------------------------
// bram_burst_reader_if
//
// Bundles the BRAM port A signals and the valid/ready output stream used by
// bram_burst_reader.
//
//   bram_wea    reader -> BRAM    write enable (reader never writes)
//   bram_addra  reader -> BRAM    read address
//   bram_dina   reader -> BRAM    write data (unused, held at zero)
//   bram_douta  BRAM   -> reader  read data, one cycle after the address
//   m_tdata     reader -> sink    stream data
//   m_tvalid    reader -> sink    stream valid
//   m_tready    sink   -> reader  stream ready
//   m_tlast     reader -> sink    marks the final word of a burst
//
// Modport master is the reader side; modport slave is the BRAM + consumer.
// ---------------------------------------------------------------------------
interface bram_burst_reader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9
);
    logic                  bram_wea;
    logic [ADDR_WIDTH-1:0] bram_addra;
    logic [DATA_WIDTH-1:0] bram_dina;
    logic [DATA_WIDTH-1:0] bram_douta;
    logic [DATA_WIDTH-1:0] m_tdata;
    logic                  m_tvalid;
    logic                  m_tready;
    logic                  m_tlast;

    modport master (
        output bram_wea,
        output bram_addra,
        output bram_dina,
        input  bram_douta,
        output m_tdata,
        output m_tvalid,
        input  m_tready,
        output m_tlast
    );

    modport slave (
        input  bram_wea,
        input  bram_addra,
        input  bram_dina,
        output bram_douta,
        input  m_tdata,
        input  m_tvalid,
        output m_tready,
        input  m_tlast
    );
endinterface

// File: rtl/bram_burst_reader.sv
// ---------------------------------------------------------------------------
// bram_burst_reader
//
// Burst read sequencer for a single-port READ_FIRST BRAM. A start command
// captures a base address and a word count; the block then walks the
// consecutive addresses (wrapping at the top of the BRAM) and streams the
// words out on a valid/ready interface. A 2-entry buffer absorbs the one-cycle
// BRAM read latency and downstream back-pressure, so one word per cycle is
// sustained while the consumer is ready.
//
// Ports:
//   clka       clock, rising edge
//   rsta       synchronous active-high reset; aborts any burst in progress
//   start      command strobe, only honoured while idle
//   base_addr  first BRAM address, captured with start
//   len        word count 0..2^ADDR_WIDTH, captured with start
//   busy       high from the cycle after start is accepted until done
//   done       one-cycle pulse when the last word has been handshaken
//   bus        BRAM port A + output stream (bram_burst_reader_if.master)
// ---------------------------------------------------------------------------
module bram_burst_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clka,
    input  logic                  rsta,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    bram_burst_reader_if.master   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0]   CNT_ZERO  = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    // Control state
    state_t                state_q,     state_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [ADDR_WIDTH:0]   issue_rem_q, issue_rem_d;  // reads still to issue
    logic [ADDR_WIDTH:0]   pop_rem_q,   pop_rem_d;    // beats still to hand out
    logic                  inflight_q,  inflight_d;   // BRAM data arriving now
    logic                  busy_q,      busy_d;
    logic                  done_q,      done_d;

    // 2-entry output buffer
    logic [DATA_WIDTH-1:0] buf0_q,      buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q,      buf1_d;
    logic                  wr_ptr_q,    wr_ptr_d;
    logic                  rd_ptr_q,    rd_ptr_d;
    logic [1:0]            cnt_q,       cnt_d;

    logic                  pop_s;
    logic                  push_s;
    logic                  issue_s;
    logic [2:0]            occ_s;
    logic [2:0]            occ_limit_s;
    logic                  tvalid_s;

    // Handshake and issue qualification.
    always_comb begin
        tvalid_s    = (cnt_q != 2'd0);
        pop_s       = tvalid_s & bus.m_tready;
        push_s      = inflight_q;
        occ_s       = {1'b0, cnt_q} + {2'b00, inflight_q};
        // occupancy after this cycle's pop must leave room for the new read
        occ_limit_s = 3'd2 + {2'b00, pop_s};
        if ((state_q == ST_READ) && (issue_rem_q != CNT_ZERO) && (occ_s < occ_limit_s)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // FSM next-state, address walk and remaining-word counters.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        issue_rem_d = issue_rem_q;
        pop_rem_d   = pop_rem_q;
        inflight_d  = issue_s;

        if (pop_s && (pop_rem_q != CNT_ZERO)) begin
            pop_rem_d = pop_rem_q - CNT_ONE;
        end else begin
            pop_rem_d = pop_rem_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    issue_rem_d = len;
                    pop_rem_d   = len;
                    state_d     = ST_READ;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_READ: begin
                if (issue_s) begin
                    addr_d      = addr_q + ADDR_ONE;   // natural wrap at 2^ADDR_WIDTH
                    issue_rem_d = issue_rem_q - CNT_ONE;
                    if (issue_rem_q == CNT_ONE) begin
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ST_READ;
                    end
                end else if (issue_rem_q == CNT_ZERO) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_FLUSH: begin
                // leave in the cycle the final beat handshakes so done follows it directly
                if ((pop_rem_q == CNT_ZERO) || ((pop_rem_q == CNT_ONE) && pop_s)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_READ) || (state_d == ST_FLUSH);
        done_d = (state_d == ST_DONE);
    end

    // Output buffer write/read pointers and occupancy.
    always_comb begin
        buf0_d   = buf0_q;
        buf1_d   = buf1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (push_s) begin
            if (wr_ptr_q == 1'b0) begin
                buf0_d = bus.bram_douta;
            end else begin
                buf1_d = bus.bram_douta;
            end
            wr_ptr_d = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;      // idle, or push and pop together
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q     <= ST_IDLE;
            addr_q      <= ADDR_ZERO;
            issue_rem_q <= CNT_ZERO;
            pop_rem_q   <= CNT_ZERO;
            inflight_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            buf0_q      <= DATA_ZERO;
            buf1_q      <= DATA_ZERO;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            issue_rem_q <= issue_rem_d;
            pop_rem_q   <= pop_rem_d;
            inflight_q  <= inflight_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    // Outputs are taken straight from registers (head of buffer, counters).
    always_comb begin
        bus.bram_wea   = 1'b0;
        bus.bram_dina  = DATA_ZERO;
        bus.bram_addra = addr_q;
        bus.m_tdata    = rd_ptr_q ? buf1_q : buf0_q;
        bus.m_tvalid   = tvalid_s;
        bus.m_tlast    = tvalid_s & (pop_rem_q == CNT_ONE);
        busy           = busy_q;
        done           = done_q;
    end

endmodule

// File: doc/bram_burst_reader.md
# bram_burst_reader

Burst read sequencer that sits directly downstream of the team's single-port READ_FIRST BRAM. On a start command it walks `len` consecutive addresses from `base_addr` and streams the words out on a valid/ready interface. It absorbs the BRAM's one-cycle read latency and downstream back-pressure with a 2-entry output buffer, and sustains one word per cycle while the consumer is ready.

## Interface
Parameters:
- `DATA_WIDTH`, 16, BRAM word width.
- `ADDR_WIDTH`, 9, BRAM address width; depth = 2^ADDR_WIDTH.

Ports:
- `clka`  in  1  clock; all logic on the rising edge.
- `rsta`  in  1  reset, synchronous, active-high.
- `start`  in  1  command strobe; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first BRAM address; captured with `start`.
- `len`  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH; captured with `start`.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse at burst end.
- `bram_wea`  out  1  BRAM write enable; constant 0.
- `bram_addra`  out  ADDR_WIDTH  BRAM address; driven from a register.
- `bram_dina`  out  DATA_WIDTH  constant 0.
- `bram_douta`  in  DATA_WIDTH  BRAM read data; valid the cycle after the address is sampled.
- `m_tdata`  out  DATA_WIDTH  stream data.
- `m_tvalid`  out  1  stream valid.
- `m_tready`  in  1  stream ready.
- `m_tlast`  out  1  high with the final word of a burst.

## Operation
- States: IDLE, READ, FLUSH, DONE.
- **IDLE:**
  - With `start`=1, capture `base_addr` into the address register and `len` into the remaining-issue counter and the remaining-pop counter.
  - Go to READ.
  - `start` in any other state is ignored.
- **READ:**
  - An issue happens this cycle if remaining-issue > 0 and (buffer count + in-flight − pop) < 2.
  - pop = `m_tvalid & m_tready`.
  - in-flight = 1 if an issue happened the previous cycle.
  - On issue: the BRAM samples `bram_addra` at the end of this cycle; the address register increments and wraps modulo 2^ADDR_WIDTH; remaining-issue decrements.
  - When remaining-issue reaches 0, go to FLUSH.
- **FLUSH:** wait until the remaining-pop counter is 0 (last word handshaken), then go to DONE.
- **DONE:** `done`=1 for exactly one cycle, `busy`=0, then go to IDLE.
- **Write-in:** `bram_douta` is written into the 2-entry FIFO buffer at the end of the cycle after an issue.
- **Output:** `m_tdata` is the buffer head and `m_tvalid` = buffer non-empty.
- **Back-pressure:** `m_tdata` and `m_tlast` hold stable while `m_tvalid & !m_tready`.
- **`m_tlast`:** high when the head is the last word, i.e. remaining-pop = 1.
- **`len`=0:** READ issues nothing and moves straight to FLUSH, then DONE. `done` pulses with no stream beats.
- **Wrap-around:** base 510, len 4, ADDR_WIDTH 9 reads addresses 510, 511, 0, 1.
- **Simultaneous push and pop** of the buffer in one cycle: count unchanged; order preserved.
- **Reset (`rsta`=1):** in any state, including mid-burst, the block returns to IDLE and the burst is aborted. In-flight data and buffer contents are discarded, no `done` pulse is produced, and partial output is not completed.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `m_tvalid`=0, `m_tlast`=0.
  - `m_tdata`=0.
  - `bram_addra`=0, `bram_wea`=0, `bram_dina`=0.
  - state IDLE; buffer count 0.
- **Start to first beat:** `start` high in cycle 0. In cycle 1 the state is READ with `bram_addra`=base and the first issue happens. In cycle 2 `bram_douta` holds word[base]. In cycle 3 `m_tvalid`=1. First-beat latency is 3 cycles.
- **Throughput:** with `m_tready` held high, one beat per cycle with no bubbles.
- **End of burst:** the last beat handshakes in cycle N. The state is DONE in cycle N+1 with `done`=1 and `busy`=0. IDLE in cycle N+2 accepts a new `start`.
- **`busy`:** high in cycles 1..N (READ and FLUSH).
- **Buffer limit:** buffer + in-flight never exceeds 2. A buffer overflow is a design error; verification asserts on it.

## Test plan
- **Basic burst:** preload mem[i]=i+0x100, `start` with base=4, len=8, `m_tready`=1 -> beats 0x104..0x10B, first `m_tvalid` 3 cycles after `start`, back-to-back beats, `m_tlast` on 0x10B, `done` one cycle after the last beat.
- **Back-pressure:** same burst with `m_tready` toggled pseudo-randomly -> identical 8-word sequence with no loss or duplication, `m_tdata` stable during stalls, buffer occupancy ≤2.
- **Wrap-around:** base=510, len=4 -> words from addresses 510, 511, 0, 1, in that order.
- **Edge lengths:** len=0 -> `done` pulse only, no beats. len=512 -> all 512 words in address order from base.
- **Start while busy:** pulse `start` with new arguments mid-burst -> ignored, original burst completes unchanged. `start` in the IDLE cycle right after `done` -> accepted.
- **Reset mid-burst:** assert `rsta` after 3 beats of a len=8 burst -> next cycle `m_tvalid`=0, `busy`=0, no `done`. A fresh burst afterwards behaves as in the basic burst.
